pulse_meter: RTL and testbench
==============================

# pulse_meter

Cycle-accurate period and high-time meter for a slow digital waveform, such as a divided clock or PWM output, measured in `clk` cycles. It sits directly downstream of the clock-divider/PWM stage and consumes its output. Each completed rising-to-rising interval yields one result: a period count, a high-time count and a one-cycle valid strobe. Results feed the status/register layer and self-checking benches.

## Interface
- `WIDTH`, 16: width of period/high-time counters and outputs.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  reset, synchronous, active-low (asserted when 0).
- `en`  input  1  measurement enable; 0 forces IDLE.
- `sig_in`  input  1  waveform under measurement; asynchronous to `clk` when the synchronizer is compiled in.
- `period`  output  WIDTH  last completed period in `clk` cycles.
- `high_time`  output  WIDTH  high portion of that period in `clk` cycles.
- `meas_valid`  output  1  one-cycle strobe; `period`/`high_time` updated this cycle.
- `overflow`  output  1  sticky flag; counter saturated before the interval closed.

## Operation
- Front end: `sig_in` is conditioned to `s`, and `s_d` is `s` delayed 1 cycle.
  - `rise = s & ~s_d`.
  - `fall = ~s & s_d`.
- FSM states: IDLE, ARM, MEASURE.
  - IDLE: `en=0`, or after reset. Goes to ARM when `en=1`.
  - ARM: waits for `rise`, then goes to MEASURE with `cnt<=1`, `high_cnt<=0`. No result is produced for the partial first interval.
  - MEASURE: `cnt<=cnt+1` every cycle.
    - On `fall`: `high_cnt<=cnt`.
    - On `rise`: `period<=cnt`, `high_time<=high_cnt`, `meas_valid<=1`, `overflow<=0`, `cnt<=1`, `high_cnt<=0`. Stays in MEASURE.
- Example: `s` high 2 cycles, low 2 cycles gives `period=4`, `high_time=2`.
- Saturation: if `cnt` equals `2^WIDTH-1` in MEASURE and neither edge occurs, then `overflow<=1`, `cnt` is cleared, FSM goes to ARM, and no `meas_valid` is produced. This covers a stuck-high or stuck-low `sig_in` and very slow inputs.
- `overflow` stays set until the next `meas_valid` or reset.
- `en` falling in any state: next cycle is IDLE, and `meas_valid=0`.
  - `period`, `high_time` and `overflow` hold their values.
  - Re-enable always restarts from ARM.
- `rise` and `fall` are mutually exclusive by construction. Back-to-back `rise` on consecutive cycles cannot occur.
- Minimum measurable period is 2 cycles.

## Timing
- Reset (`rst=0` at a clock edge) gives:
  - state IDLE
  - `cnt=0`, `high_cnt=0`
  - `period=0`, `high_time=0`
  - `meas_valid=0`, `overflow=0`
  - front-end registers 0
- Reset mid-measurement discards the interval. No strobe is produced.
- All outputs are registered.
- Latency from `sig_in` rising (as sampled at edge k) to `meas_valid` high:
  - sync compiled in: asserted after edge k+3.
  - sync compiled out: asserted after edge k+1.
- Both edges are delayed equally, so measured values are unaffected by latency.
- `meas_valid` is exactly 1 cycle wide. Consecutive strobes are at least 2 cycles apart.

## Configuration
- `PULSE_METER_SYNC_EN` defined:
  - `sig_in` passes through a 2-flop synchronizer before edge detection.
  - Safe for asynchronous inputs.
  - Output latency as above, +2 cycles.
- Not defined:
  - `sig_in` feeds edge detection directly (`s = sig_in`, `s_d` registered).
  - `sig_in` must be synchronous to `clk`.

## Structure
- Shared package `pulse_meter_pkg`:
  - state typedef `meter_state_t` {IDLE, ARM, MEASURE}
  - default `WIDTH` constant
- One sub-module, `edge_sync`.
  - Contains the optional synchronizer and the `s_d` register.
  - Outputs `rise` and `fall`.
  - Takes the same `clk`/`rst`.
- FSM and counters stay in `pulse_meter`.

## Test plan
- Reset: hold `rst=0` 3 cycles with `sig_in` toggling. Required response: all outputs 0, no `meas_valid`.
- Steady square wave, `en=1`, `sig_in` high 3 / low 5 cycles, repeated. Required response:
  - first strobe after the second rising edge
  - each strobe has `period=8`, `high_time=3`
  - strobes exactly 8 cycles apart
- Duty change on the fly: high 2/low 2, then high 6/low 2. Required response: `period=4`/`high_time=2`, then `8`/`6` starting from the first full new interval.
- Overflow with `WIDTH=4`: `sig_in` held high 20 cycles after a rise. Required response:
  - `overflow=1` at `cnt=15`, no strobe
  - next full interval high 3/low 3 gives `meas_valid`, `period=6`, `overflow` cleared
- Enable drop: deassert `en` mid-interval for 10 cycles. Required response:
  - outputs held, no strobe
  - after re-enable, first strobe only after two rises
- Reset mid-measurement: `rst=0` for 1 cycle while in MEASURE. Required response: all outputs 0, and that interval yields no strobe.

Source files
------------

// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse_meter block.
//   meter_state_t : FSM state encoding (idle / armed / measuring)
//   DEFAULT_WIDTH : default width of the period and high-time counters
package pulse_meter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StMeasure
  } meter_state_t;

endpackage

// File: rtl/pulse_meter_if.sv
// Bundles the measurement-facing signals of pulse_meter.
//   en         : measurement enable (master -> meter)
//   sig_in     : waveform under measurement (master -> meter)
//   period     : last completed period in clk cycles (meter -> master)
//   high_time  : high portion of that period (meter -> master)
//   meas_valid : one-cycle strobe, period/high_time updated (meter -> master)
//   overflow   : sticky saturation flag (meter -> master)
interface pulse_meter_if
  import pulse_meter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             en;
  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             meas_valid;
  logic             overflow;

  modport master (
    output en,
    output sig_in,
    input  period,
    input  high_time,
    input  meas_valid,
    input  overflow
  );

  modport slave (
    input  en,
    input  sig_in,
    output period,
    output high_time,
    output meas_valid,
    output overflow
  );

endinterface

// File: rtl/edge_sync.sv
// Front end of pulse_meter: conditions sig_in and detects its edges.
//   clk    : system clock
//   rst    : synchronous active-low reset
//   sig_in : raw waveform
//   rise   : conditioned signal went 0 -> 1 this cycle
//   fall   : conditioned signal went 1 -> 0 this cycle
// Macro PULSE_METER_SYNC_EN inserts a 2-flop synchronizer ahead of edge
// detection; without it sig_in must already be synchronous to clk.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic s;
  logic s_d_q;

`ifdef PULSE_METER_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = sig_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      s_d_q <= 1'b0;
    end else begin
      s_d_q <= s;
    end
  end

  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

endmodule

// File: rtl/pulse_meter.sv
// Period and high-time meter for a slow waveform, counted in clk cycles.
// Every completed rising-to-rising interval produces period, high_time and a
// one-cycle meas_valid strobe. The partial interval after arming is dropped.
//   clk : system clock
//   rst : synchronous active-low reset
//   bus : pulse_meter_if slave (en, sig_in in; period, high_time,
//         meas_valid, overflow out)
// Macro PULSE_METER_SYNC_EN (in edge_sync) adds a 2-flop input synchronizer.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  pulse_meter_if.slave   bus
);

  localparam logic [WIDTH-1:0] MaxCnt = '1;
  localparam logic [WIDTH-1:0] OneCnt = WIDTH'(1);

  meter_state_t     state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] high_cnt_q, high_cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_time_q, high_time_d;
  logic             meas_valid_q, meas_valid_d;
  logic             overflow_q, overflow_d;
  logic             rise;
  logic             fall;

  edge_sync u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_in (bus.sig_in),
    .rise   (rise),
    .fall   (fall)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    high_cnt_d   = high_cnt_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    meas_valid_d = 1'b0;
    overflow_d   = overflow_q;

    if (!bus.en) begin
      // Results and the sticky flag survive a disable; only the FSM restarts.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StArm;
        end
        StArm: begin
          if (rise) begin
            state_d    = StMeasure;
            cnt_d      = OneCnt;
            high_cnt_d = '0;
          end
        end
        StMeasure: begin
          if (rise) begin
            period_d     = cnt_q;
            high_time_d  = high_cnt_q;
            meas_valid_d = 1'b1;
            overflow_d   = 1'b0;
            cnt_d        = OneCnt;
            high_cnt_d   = '0;
          end else if (fall) begin
            high_cnt_d = cnt_q;
            // Hold at max so the following edge-free cycle flags overflow.
            cnt_d      = (cnt_q == MaxCnt) ? cnt_q : cnt_q + OneCnt;
          end else if (cnt_q == MaxCnt) begin
            overflow_d = 1'b1;
            cnt_d      = '0;
            state_d    = StArm;
          end else begin
            cnt_d = cnt_q + OneCnt;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      high_cnt_q   <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      high_cnt_q   <= high_cnt_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_time_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Self-checking bench for pulse_meter, built with WIDTH=4 so saturation is
// reachable quickly. Expected (period, high_time) pairs are queued as the
// closing rising edge of each full interval is driven and popped whenever
// the DUT strobes meas_valid.
module tb_pulse_meter;

  localparam int unsigned W = 4;
`ifdef PULSE_METER_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif

  logic clk;
  logic rst;

  pulse_meter_if #(.WIDTH(W)) bus ();

  pulse_meter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc_cnt     = 0;

  logic [2*W-1:0] exp_q[$];
  int             strobe_t[$];

  int unsigned prev_hi;
  int unsigned prev_lo;
  bit          prev_valid;

  // Scoreboard: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    cyc_cnt++;
    if (bus.meas_valid === 1'b1) begin
      strobe_t.push_back(cyc_cnt);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: got period=%0d high_time=%0d at cycle %0d, want none",
                 bus.period, bus.high_time, cyc_cnt);
      end else begin
        e = exp_q.pop_front();
        if ({bus.period, bus.high_time} !== e) begin
          miscompares++;
          $display("FAIL strobe_value: got period=%0d high_time=%0d, want period=%0d high_time=%0d",
                   bus.period, bus.high_time, e[2*W-1:W], e[W-1:0]);
        end
      end
      vectors++;
      if (bus.overflow !== 1'b0) begin
        miscompares++;
        $display("FAIL strobe_overflow: got %b, want 0", bus.overflow);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int unsigned p, input int unsigned h);
    exp_q.push_back({W'(p), W'(h)});
  endtask

  // One waveform period starting with a rising edge; that rise closes the
  // previous full period, if any.
  task automatic wave(input int unsigned hi, input int unsigned lo);
    if (prev_valid) push_exp(prev_hi + prev_lo, prev_hi);
    prev_hi    = hi;
    prev_lo    = lo;
    prev_valid = 1'b1;
    bus.sig_in = 1'b1;
    cyc(hi);
    bus.sig_in = 1'b0;
    cyc(lo);
  endtask

  task automatic close_wave();
    if (prev_valid) push_exp(prev_hi + prev_lo, prev_hi);
    prev_valid = 1'b0;
    bus.sig_in = 1'b1;
    cyc(1);
  endtask

  task automatic restart();
    bus.en     = 1'b0;
    bus.sig_in = 1'b0;
    prev_valid = 1'b0;
    cyc(4);
    bus.en = 1'b1;
    cyc(2);
  endtask

  task automatic drain(input string name);
    cyc(8);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing_strobes: got %0d outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    bus.en     = 1'b1;
    bus.sig_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.sig_in = ~bus.sig_in;
      cyc(1);
      vectors++;
      if ({bus.period, bus.high_time, bus.meas_valid, bus.overflow} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: got period=%0d high_time=%0d valid=%b ovf=%b, want all 0",
                 bus.period, bus.high_time, bus.meas_valid, bus.overflow);
      end
    end
    rst = 1'b1;
    bus.en = 1'b0;
    bus.sig_in = 1'b0;
    cyc(2);
  endtask

  task automatic test_square();
    restart();
    strobe_t.delete();
    for (int i = 0; i < 4; i++) wave(3, 5);
    close_wave();
    drain("square");
    vectors++;
    if (strobe_t.size() != 4) begin
      miscompares++;
      $display("FAIL square_count: got %0d strobes, want 4", strobe_t.size());
    end
    for (int i = 1; i < strobe_t.size(); i++) begin
      vectors++;
      if (strobe_t[i] - strobe_t[i-1] != 8) begin
        miscompares++;
        $display("FAIL square_spacing: got %0d cycles, want 8", strobe_t[i] - strobe_t[i-1]);
      end
    end
  endtask

  task automatic test_duty_change();
    restart();
    for (int i = 0; i < 3; i++) wave(2, 2);
    for (int i = 0; i < 3; i++) wave(6, 2);
    close_wave();
    drain("duty");
  endtask

  task automatic test_overflow();
    restart();
    bus.sig_in = 1'b1;
    cyc(15 + SyncLat);
    vectors++;
    if (bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_early: got %b, want 0", bus.overflow);
    end
    cyc(1);
    vectors++;
    if (bus.overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_set: got %b, want 1", bus.overflow);
    end
    cyc(4);
    bus.sig_in = 1'b0;
    cyc(3);
    wave(3, 3);
    vectors++;
    if (bus.overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_sticky: got %b, want 1", bus.overflow);
    end
    close_wave();
    drain("overflow");
    vectors++;
    if (bus.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_clear: got %b, want 0", bus.overflow);
    end
  endtask

  task automatic test_en_drop();
    restart();
    wave(3, 5);
    wave(3, 5);
    close_wave();
    cyc(4);
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.sig_in = (i < 6) ? ~bus.sig_in : 1'b0;
      cyc(1);
      vectors++;
      if ({bus.period, bus.high_time, bus.overflow} !== {W'(8), W'(3), 1'b0}) begin
        miscompares++;
        $display("FAIL en_drop_hold: got period=%0d high_time=%0d ovf=%b, want 8 3 0",
                 bus.period, bus.high_time, bus.overflow);
      end
    end
    bus.en = 1'b1;
    cyc(2);
    strobe_t.delete();
    wave(2, 3);
    vectors++;
    if (strobe_t.size() != 0) begin
      miscompares++;
      $display("FAIL en_drop_first_rise: got %0d strobes, want 0", strobe_t.size());
    end
    wave(2, 3);
    close_wave();
    drain("en_drop");
  endtask

  task automatic test_reset_mid();
    restart();
    wave(3, 5);
    close_wave();
    cyc(4);
    bus.sig_in = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    vectors++;
    if ({bus.period, bus.high_time, bus.meas_valid, bus.overflow} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got period=%0d high_time=%0d valid=%b ovf=%b, want 0",
               bus.period, bus.high_time, bus.meas_valid, bus.overflow);
    end
    cyc(2);
    prev_valid = 1'b0;
    wave(3, 5);
    close_wave();
    drain("reset_mid");
  endtask

  task automatic test_back_to_back();
    restart();
    strobe_t.delete();
    for (int i = 0; i < 4; i++) wave(1, 1);
    close_wave();
    drain("b2b");
    vectors++;
    if (strobe_t.size() != 4) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d strobes, want 4", strobe_t.size());
    end
    for (int i = 1; i < strobe_t.size(); i++) begin
      vectors++;
      if (strobe_t[i] - strobe_t[i-1] != 2) begin
        miscompares++;
        $display("FAIL b2b_spacing: got %0d cycles, want 2", strobe_t[i] - strobe_t[i-1]);
      end
    end
  endtask

  initial begin
    rst        = 1'b0;
    bus.en     = 1'b0;
    bus.sig_in = 1'b0;
    prev_valid = 1'b0;
    prev_hi    = 0;
    prev_lo    = 0;
    test_reset();
    test_square();
    test_duty_change();
    test_overflow();
    test_en_drop();
    test_reset_mid();
    test_back_to_back();
    bus.en = 1'b0;
    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
